// File: rtl/iso14443a_pkg.sv
// Shared ISO/IEC 14443-2 Type A types and constants for the PICC transmit path.
package iso14443a_pkg;

   typedef enum logic [1:0] {TX_IDLE, TX_SOC, TX_DATA, TX_EOC} tx_state_t;

   localparam int FC_TICKS_PER_BIT = 128;
   localparam int SUBCARRIER_DIV   = 16;

   // Manchester on-off keying: logic 1 modulates the first half, logic 0 the second.
   function automatic logic manchester_lm(input logic val, input logic half, input logic sc);
      if (val) return half ? 1'b0 : sc;
      else     return half ? sc : 1'b0;
   endfunction

endpackage

// File: rtl/load_mod_tx.sv
// PICC load-modulation transmitter: SOC, data bits, EOC; lm_out high one tick after trigger accept.
// Bits are pulled one per bit period; in_ready/underrun are registered pulses on the last tick of a bit.
module load_mod_tx #(
   parameter int TICKS_PER_BIT  = iso14443a_pkg::FC_TICKS_PER_BIT,
   parameter int SUBCARRIER_DIV = iso14443a_pkg::SUBCARRIER_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic trigger,
   input  logic in_valid,
   input  logic in_data,
   input  logic in_last,
   output logic in_ready,
   output logic lm_out,
   output logic busy,
   output logic underrun
);
   import iso14443a_pkg::*;

   localparam int CW = $clog2(TICKS_PER_BIT);
   localparam int SW = $clog2(SUBCARRIER_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ASK  = CW'(TICKS_PER_BIT - 2);

   tx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bit_q, bit_d;
   logic          last_q, last_d;
   logic          lm_out_q, lm_out_d;
   logic          busy_q, busy_d;
   logic          in_ready_q, in_ready_d;
   logic          underrun_q, underrun_d;
   logic          need_bit;
   logic          half_d, sc_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      last_d     = last_q;
      in_ready_d = 1'b0;
      underrun_d = 1'b0;
      need_bit   = (state_q == TX_SOC) || ((state_q == TX_DATA) && !last_q);

      unique case (state_q)
         TX_IDLE: begin
            cnt_d = '0;
            if (trigger) begin
               if (in_valid) state_d = TX_SOC;
               else          underrun_d = 1'b1;
            end
         end
         TX_SOC, TX_DATA: begin
            // Decide one tick early so the registered in_ready lands on the last tick of the bit.
            if ((cnt_q == CNT_ASK) && need_bit) begin
               if (in_valid) in_ready_d = 1'b1;
               else          underrun_d = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
               if (in_ready_q) begin
                  bit_d   = in_data;
                  last_d  = in_last;
                  state_d = TX_DATA;
               end else begin
                  state_d = TX_EOC;
               end
            end
         end
         TX_EOC: begin
            if (cnt_q == CNT_LAST) state_d = TX_IDLE;
         end
         default: state_d = TX_IDLE;
      endcase

      half_d = cnt_d[CW-1];
      sc_d   = ~cnt_d[SW-1];
      unique case (state_d)
         TX_SOC:  lm_out_d = manchester_lm(1'b1, half_d, sc_d);
         TX_DATA: lm_out_d = manchester_lm(bit_d, half_d, sc_d);
         default: lm_out_d = 1'b0;
      endcase
      busy_d = (state_d != TX_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         cnt_q      <= '0;
         bit_q      <= 1'b0;
         last_q     <= 1'b0;
         lm_out_q   <= 1'b0;
         busy_q     <= 1'b0;
         in_ready_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         last_q     <= last_d;
         lm_out_q   <= lm_out_d;
         busy_q     <= busy_d;
         in_ready_q <= in_ready_d;
         underrun_q <= underrun_d;
      end
   end

   assign lm_out   = lm_out_q;
   assign busy     = busy_q;
   assign in_ready = in_ready_q;
   assign underrun = underrun_q;

endmodule
